vga_bounce_box: RTL and testbench

- Pixel-generation stage downstream of the 640x480 display timing generator.
- Consumes that generator's screen position, syncs and data enable, and draws one solid square on a black background.
- The square moves a fixed step once per frame and bounces off the screen edges. Its colour cycles on every bounce.
- Outputs 12-bit RGB plus syncs, delay-matched, for direct connection to the VGA pins.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/box_axis_mover.sv | 67 ++++++
 rtl/vga_bounce_box.sv | 136 +++++++++++++
 tb/tb_vga_bounce_box.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480 timing constants and pixel types
// for the pixel-generation stages.
package vga_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;

  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = 800;

  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = 525;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  typedef enum logic {
    POS = 1'b0,
    NEG = 1'b1
  } dir_t;

  localparam rgb12_t PALETTE [4] = '{
    rgb12_t'(12'hFFF),
    rgb12_t'(12'hF00),
    rgb12_t'(12'h0F0),
    rgb12_t'(12'h00F)
  };

endpackage

// File: rtl/box_axis_mover.sv
// box_axis_mover: one axis of the bouncing square; steps once per
// enabled tick and reflects at 0 and LIMIT.
module box_axis_mover
  import vga_pkg::*;
#(
  parameter int LIMIT = 608,
  parameter int SPEED = 4,
  parameter int START = 100
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       tick_en,
  output logic [9:0] pos,
  output logic       bounce
);

  localparam logic [10:0] LIM = 11'(LIMIT);
  localparam logic [10:0] SPD = 11'(SPEED);

  dir_t        dir;
  logic [10:0] pos_w;
  logic [10:0] up;
  logic [9:0]  dn;
  logic        hit_hi;
  logic        hit_lo;

  // 11-bit sums so pos+SPEED can never wrap
  assign pos_w  = {1'b0, pos};
  assign up     = pos_w + SPD;
  assign dn     = pos - SPD[9:0];
  assign hit_hi = (up >= LIM);
  assign hit_lo = (pos_w <= SPD);

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      pos    <= 10'(START);
      dir    <= POS;
      bounce <= 1'b0;
    end else begin
      bounce <= 1'b0;
      if (tick_en) begin
        unique case (dir)
          POS: begin
            if (hit_hi) begin
              pos    <= LIM[9:0];
              dir    <= NEG;
              bounce <= 1'b1;
            end else begin
              pos <= up[9:0];
            end
          end
          NEG: begin
            if (hit_lo) begin
              pos    <= '0;
              dir    <= POS;
              bounce <= 1'b1;
            end else begin
              pos <= dn;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/vga_bounce_box.sv
// vga_bounce_box: draws a bouncing solid square behind the 480p
// timing generator, two-stage pipeline with delay-matched syncs.
module vga_bounce_box
  import vga_pkg::*;
#(
  parameter int H_RES    = vga_pkg::H_RES,
  parameter int V_RES    = vga_pkg::V_RES,
  parameter int BOX_SIZE = 32,
  parameter int SPEED    = 4,
  parameter int START_X  = 100,
  parameter int START_Y  = 60
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       de,
  input  logic       run,
  output logic       vga_hsync,
  output logic       vga_vsync,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic [7:0] bounce_cnt
);

  localparam int          LX     = H_RES - BOX_SIZE;
  localparam int          LY     = V_RES - BOX_SIZE;
  localparam logic [9:0]  V_TICK = 10'(V_RES);
  localparam logic [10:0] BOX    = 11'(BOX_SIZE);

  logic [9:0] sx1;
  logic [9:0] sy1;
  logic       de1;
  logic       hs1;
  logic       vs1;

  logic       tick;
  logic       tick_en;
  logic [9:0] bx;
  logic [9:0] by;
  logic       bounce_x;
  logic       bounce_y;
  logic [1:0] col_idx;

  logic       in_x;
  logic       in_y;
  rgb12_t     pix;
  rgb12_t     rgb_q;

  // first blanking line start: the visible frame is already done
  assign tick    = (sx == 10'd0) && (sy == V_TICK);
  assign tick_en = tick & run;

  box_axis_mover #(
    .LIMIT (LX),
    .SPEED (SPEED),
    .START (START_X)
  ) u_x (
    .clk_pix (clk_pix),
    .rst     (rst),
    .tick_en (tick_en),
    .pos     (bx),
    .bounce  (bounce_x)
  );

  box_axis_mover #(
    .LIMIT (LY),
    .SPEED (SPEED),
    .START (START_Y)
  ) u_y (
    .clk_pix (clk_pix),
    .rst     (rst),
    .tick_en (tick_en),
    .pos     (by),
    .bounce  (bounce_y)
  );

  // corner hits pulse both axes together and count once
  always_ff @(posedge clk_pix) begin
    if (rst) begin
      col_idx    <= '0;
      bounce_cnt <= '0;
    end else if (bounce_x | bounce_y) begin
      col_idx    <= col_idx + 2'd1;
      bounce_cnt <= bounce_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      sx1 <= '0;
      sy1 <= '0;
      de1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
    end else begin
      sx1 <= sx;
      sy1 <= sy;
      de1 <= de;
      hs1 <= hsync;
      vs1 <= vsync;
    end
  end

  assign in_x = ({1'b0, sx1} >= {1'b0, bx})
             && ({1'b0, sx1} < ({1'b0, bx} + BOX));
  assign in_y = ({1'b0, sy1} >= {1'b0, by})
             && ({1'b0, sy1} < ({1'b0, by} + BOX));

  always_comb begin
    pix = '0;
    if (de1 && in_x && in_y) begin
      pix = PALETTE[col_idx];
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      rgb_q     <= '0;
    end else begin
      vga_hsync <= hs1;
      vga_vsync <= vs1;
      rgb_q     <= pix;
    end
  end

  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_bounce_box.sv
// tb_vga_bounce_box: three instances (default, right-edge, corner)
// driven in lockstep and scored against an arithmetic model.
module tb_vga_bounce_box;

  localparam int LX  = 608;
  localparam int LY  = 448;
  localparam int S   = 4;
  localparam int BOX = 32;

  typedef struct packed {
    logic [2:0][11:0] rgb;
    logic             hs;
    logic             vs;
  } exp_t;

  typedef struct {
    int         x;
    int         y;
    bit         de;
    bit         hs;
    bit         vs;
    logic [11:0] rgb;
  } vec_t;

  logic       clk_pix = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sx = '0;
  logic [9:0] sy = '0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic       de = 1'b0;
  logic       run = 1'b0;

  logic       hs_o  [3];
  logic       vs_o  [3];
  logic [3:0] r_o   [3];
  logic [3:0] g_o   [3];
  logic [3:0] b_o   [3];
  logic [7:0] cnt_o [3];

  always #5 clk_pix = ~clk_pix;

  vga_bounce_box dut0 (
    .clk_pix (clk_pix), .rst (rst), .sx (sx), .sy (sy),
    .hsync (hsync), .vsync (vsync), .de (de), .run (run),
    .vga_hsync (hs_o[0]), .vga_vsync (vs_o[0]),
    .vga_r (r_o[0]), .vga_g (g_o[0]), .vga_b (b_o[0]),
    .bounce_cnt (cnt_o[0])
  );

  vga_bounce_box #(.START_X(600)) dut1 (
    .clk_pix (clk_pix), .rst (rst), .sx (sx), .sy (sy),
    .hsync (hsync), .vsync (vsync), .de (de), .run (run),
    .vga_hsync (hs_o[1]), .vga_vsync (vs_o[1]),
    .vga_r (r_o[1]), .vga_g (g_o[1]), .vga_b (b_o[1]),
    .bounce_cnt (cnt_o[1])
  );

  vga_bounce_box #(.START_X(606), .START_Y(446)) dut2 (
    .clk_pix (clk_pix), .rst (rst), .sx (sx), .sy (sy),
    .hsync (hsync), .vsync (vsync), .de (de), .run (run),
    .vga_hsync (hs_o[2]), .vga_vsync (vs_o[2]),
    .vga_r (r_o[2]), .vga_g (g_o[2]), .vga_b (b_o[2]),
    .bounce_cnt (cnt_o[2])
  );

  int n_cmp = 0;
  int n_err = 0;
  int since = 2;
  exp_t q[$];

  int bx0 [3] = '{100, 600, 606};
  int by0 [3] = '{60, 60, 446};
  int mbx [3];
  int mby [3];
  int mdx [3];
  int mdy [3];
  int midx[3];
  int mcnt[3];
  logic [11:0] pal [4] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F};

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      mbx[k] = bx0[k];
      mby[k] = by0[k];
      mdx[k] = 1;
      mdy[k] = 1;
      midx[k] = 0;
      mcnt[k] = 0;
    end
  endtask

  task automatic axis(inout int p, inout int d, input int l,
                      inout bit b);
    int n;
    n = p + d * S;
    if (d > 0 && n >= l) begin
      p = l; d = -1; b = 1'b1;
    end else if (d < 0 && n <= 0) begin
      p = 0; d = 1; b = 1'b1;
    end else begin
      p = n;
    end
  endtask

  task automatic m_tick();
    for (int k = 0; k < 3; k++) begin
      bit b;
      int p;
      int d;
      b = 1'b0;
      p = mbx[k]; d = mdx[k];
      axis(p, d, LX, b);
      mbx[k] = p; mdx[k] = d;
      p = mby[k]; d = mdy[k];
      axis(p, d, LY, b);
      mby[k] = p; mdy[k] = d;
      if (b) begin
        midx[k] = (midx[k] + 1) % 4;
        mcnt[k] = (mcnt[k] + 1) % 256;
      end
    end
  endtask

  function automatic logic [11:0] m_rgb(int k, int x, int y, bit d);
    if (d && x >= mbx[k] && x < mbx[k] + BOX
          && y >= mby[k] && y < mby[k] + BOX)
      return pal[midx[k]];
    return 12'h000;
  endfunction

  task automatic step(input int x, input int y, input bit d,
                      input bit h, input bit v, input bit r,
                      input int tdut, input logic [11:0] trgb);
    exp_t e;
    bit tk;
    @(negedge clk_pix);
    rst = 1'b0;
    sx = 10'(x); sy = 10'(y);
    de = d; hsync = h; vsync = v; run = r;
    for (int k = 0; k < 3; k++) e.rgb[k] = m_rgb(k, x, y, d);
    if (tdut >= 0) e.rgb[tdut] = trgb;
    e.hs = h;
    e.vs = v;
    q.push_back(e);
    tk = (x == 0 && y == 480);
    if (tk && r) m_tick();
    if (tk) since = 0;
    else since++;
    @(posedge clk_pix);
    #1;
    if (q.size() == 2) begin
      e = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rgb dut%0d", k),
            32'({r_o[k], g_o[k], b_o[k]}), 32'(e.rgb[k]));
        chk($sformatf("hsync dut%0d", k), 32'(hs_o[k]), 32'(e.hs));
        chk($sformatf("vsync dut%0d", k), 32'(vs_o[k]), 32'(e.vs));
      end
    end
    if (since >= 2)
      for (int k = 0; k < 3; k++)
        chk($sformatf("bounce_cnt dut%0d", k),
            32'(cnt_o[k]), 32'(mcnt[k]));
  endtask

  task automatic idle(int n, bit r);
    for (int i = 0; i < n; i++) step(5, 500, 0, 1, 1, r, -1, 12'h0);
  endtask

  task automatic tick(bit r);
    step(0, 480, 0, 1, 1, r, -1, 12'h0);
    idle(2, r);
  endtask

  task automatic probe(int x, int y, int k, logic [11:0] want);
    step(x, y, 1, 1, 1, 1, k, want);
  endtask

  task automatic do_reset(int n, int x, int y, bit r);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_pix);
      rst = 1'b1;
      sx = 10'(x); sy = 10'(y);
      de = 1'b0; hsync = 1'b1; vsync = 1'b1; run = r;
      @(posedge clk_pix);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("rst hsync dut%0d", k), 32'(hs_o[k]), 32'd1);
        chk($sformatf("rst vsync dut%0d", k), 32'(vs_o[k]), 32'd1);
        chk($sformatf("rst rgb dut%0d", k),
            32'({r_o[k], g_o[k], b_o[k]}), 32'd0);
        chk($sformatf("rst cnt dut%0d", k), 32'(cnt_o[k]), 32'd0);
      end
    end
    q.delete();
    m_reset();
    since = 2;
  endtask

  initial begin
    vec_t tbl [10];
    tbl[0] = '{100,  60, 1, 1, 1, 12'hFFF};
    tbl[1] = '{132,  60, 1, 1, 1, 12'h000};
    tbl[2] = '{100,  60, 0, 1, 1, 12'h000};
    tbl[3] = '{131,  91, 1, 1, 1, 12'hFFF};
    tbl[4] = '{ 99,  60, 1, 1, 1, 12'h000};
    tbl[5] = '{100,  92, 1, 1, 1, 12'h000};
    tbl[6] = '{100,  59, 1, 0, 1, 12'h000};
    tbl[7] = '{120,  70, 1, 1, 0, 12'hFFF};
    tbl[8] = '{131,  60, 1, 0, 0, 12'hFFF};
    tbl[9] = '{  0,   0, 0, 1, 1, 12'h000};

    do_reset(3, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step(tbl[i].x, tbl[i].y, tbl[i].de, tbl[i].hs, tbl[i].vs,
           0, 0, tbl[i].rgb);
    idle(2, 0);

    // corner instance hits both limits on the first tick
    tick(1);
    chk("corner cnt", 32'(cnt_o[2]), 32'd1);
    chk("dut0 cnt t1", 32'(cnt_o[0]), 32'd0);
    probe(608, 448, 2, 12'hF00);
    probe(607, 448, 2, 12'h000);
    probe(608, 447, 2, 12'h000);
    probe(104, 64, 0, 12'hFFF);
    probe(103, 64, 0, 12'h000);

    tick(1);
    chk("right cnt t2", 32'(cnt_o[1]), 32'd1);
    chk("corner cnt t2", 32'(cnt_o[2]), 32'd1);
    probe(608, 68, 1, 12'hF00);
    probe(607, 68, 1, 12'h000);

    tick(1);
    probe(604, 72, 1, 12'hF00);
    probe(636, 72, 1, 12'h000);
    probe(635, 103, 1, 12'hF00);
    probe(635, 104, 1, 12'h000);

    for (int i = 0; i < 5; i++) tick(0);
    chk("pause cnt0", 32'(cnt_o[0]), 32'd0);
    chk("pause cnt1", 32'(cnt_o[1]), 32'd1);
    chk("pause cnt2", 32'(cnt_o[2]), 32'd1);
    probe(604, 72, 1, 12'hF00);
    probe(112, 72, 0, 12'hFFF);
    probe(111, 72, 0, 12'h000);

    for (int t = 0; t < 320; t++) begin
      tick($urandom_range(0, 3) != 0);
      for (int i = 0; i < 6; i++) begin
        int k;
        int x;
        int y;
        k = int'($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 1) begin
          x = mbx[k] + int'($urandom_range(0, 39)) - 4;
          y = mby[k] + int'($urandom_range(0, 39)) - 4;
        end else begin
          x = int'($urandom_range(0, 639));
          y = int'($urandom_range(0, 479));
        end
        if (x < 0) x = 0;
        if (x > 639) x = 639;
        if (y < 0) y = 0;
        if (y > 479) y = 479;
        step(x, y, $urandom_range(0, 9) != 0,
             $urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0,
             1, -1, 12'h0);
      end
    end

    for (int i = 0; i < 4; i++) step(300 + i, 200, 1, 1, 1, 1, -1, 12'h0);
    // reset coincides with a tick that must not move anything
    do_reset(1, 0, 480, 1);
    idle(2, 1);
    probe(100, 60, 0, 12'hFFF);
    probe(99, 60, 0, 12'h000);
    probe(600, 60, 1, 12'hFFF);
    probe(606, 446, 2, 12'hFFF);
    probe(605, 446, 2, 12'h000);
    idle(2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
